alu_exe_unit: RTL

Execute-side counterpart of the select/wakeup stage: accepts one ALU instruction per cycle issued by the ALU reservation station, computes it in a registered stage, and queues the result in a 2-entry result buffer. The buffer head drives the writeback valid/ready handshake toward the ROB/RRF. The same head drives the result/tag broadcast that feeds the reservation stations' `exe_result_N_i`/`exe_result_N_dst_i` forwarding inputs. It sits between the SW stage and the writeback arbiter. It is the producer end of the forwarding bus the SW stage consumes.

---
 rtl/alu_exe_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exe_unit.sv
// ALU execute stage: registered E1 evaluation feeding a 2-entry result buffer whose head drives writeback and the forwarding broadcast.
// Optional build macro ALU_EXE_PERF_CNT_EN adds issue/stall performance counters.
module alu_exe_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              kill_i,
  input  logic              issue_valid_i,
  output logic              issue_stall_o,
  input  logic [DATA_W-1:0] issue_op_1_i,
  input  logic [DATA_W-1:0] issue_op_2_i,
  input  logic [DATA_W-1:0] issue_imm_i,
  input  logic              issue_src_b_imm_i,
  input  logic [ADDR_W-1:0] issue_pc_i,
  input  logic [TAG_W-1:0]  issue_rrf_tag_i,
  input  logic              issue_dst_val_i,
  input  logic [OP_W-1:0]   issue_alu_op_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [TAG_W-1:0]  wb_rrf_tag_o,
  output logic              wb_dst_val_o,
  output logic [ADDR_W-1:0] wb_pc_o,
  output logic [DATA_W-1:0] exe_result_o,
  output logic [TAG_W-1:0]  exe_result_dst_o
`ifdef ALU_EXE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issue_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0] ALU_OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_OP_SLL  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_OP_SLT  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OP_SLTU = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_OP_SRL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_OP_AND  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_OP_SUB  = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_OP_SRA  = OP_W'(13);

  logic              issue_accept;
  logic              push;
  logic              pop;

  logic              e1_valid;
  logic [DATA_W-1:0] e1_op_1;
  logic [DATA_W-1:0] e1_op_2;
  logic [DATA_W-1:0] e1_imm;
  logic              e1_src_b_imm;
  logic [ADDR_W-1:0] e1_pc;
  logic [TAG_W-1:0]  e1_tag;
  logic              e1_dst_val;
  logic [OP_W-1:0]   e1_alu_op;

  logic [DATA_W-1:0]  operand_b;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  e1_result;

  logic [DATA_W-1:0] fifo_result [2];
  logic [TAG_W-1:0]  fifo_tag    [2];
  logic              fifo_dst    [2];
  logic [ADDR_W-1:0] fifo_pc     [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  // Credit check counts the in-flight E1 entry and ignores any same-cycle pop.
  assign issue_stall_o = (3'(count) + 3'(e1_valid)) >= 3'd2;
  assign issue_accept  = issue_valid_i & ~issue_stall_o & ~kill_i;
  assign push          = e1_valid;
  assign pop           = wb_valid_o & wb_ready_i;

  // E1 operand/control register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      e1_valid     <= 1'b0;
      e1_op_1      <= '0;
      e1_op_2      <= '0;
      e1_imm       <= '0;
      e1_src_b_imm <= 1'b0;
      e1_pc        <= '0;
      e1_tag       <= '0;
      e1_dst_val   <= 1'b0;
      e1_alu_op    <= '0;
    end else begin
      e1_valid <= issue_accept;
      if (issue_accept) begin
        e1_op_1      <= issue_op_1_i;
        e1_op_2      <= issue_op_2_i;
        e1_imm       <= issue_imm_i;
        e1_src_b_imm <= issue_src_b_imm_i;
        e1_pc        <= issue_pc_i;
        e1_tag       <= issue_rrf_tag_i;
        e1_dst_val   <= issue_dst_val_i;
        e1_alu_op    <= issue_alu_op_i;
      end
    end
  end

  // E1 evaluation
  always_comb begin
    operand_b = e1_src_b_imm ? e1_imm : e1_op_2;
    shamt     = operand_b[SHAMT_W-1:0];
    e1_result = '0;
    case (e1_alu_op)
      ALU_OP_ADD:  e1_result = e1_op_1 + operand_b;
      ALU_OP_SUB:  e1_result = e1_op_1 - operand_b;
      ALU_OP_AND:  e1_result = e1_op_1 & operand_b;
      ALU_OP_OR:   e1_result = e1_op_1 | operand_b;
      ALU_OP_XOR:  e1_result = e1_op_1 ^ operand_b;
      ALU_OP_SLL:  e1_result = e1_op_1 << shamt;
      ALU_OP_SRL:  e1_result = e1_op_1 >> shamt;
      ALU_OP_SRA:  e1_result = $unsigned($signed(e1_op_1) >>> shamt);
      ALU_OP_SLT:  e1_result = DATA_W'($signed(e1_op_1) < $signed(operand_b));
      ALU_OP_SLTU: e1_result = DATA_W'(e1_op_1 < operand_b);
      default:     e1_result = '0;
    endcase
  end

  // Result buffer payload; stale entries are never exposed because the head is gated by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_result[wr_ptr] <= e1_result;
      fifo_tag[wr_ptr]    <= e1_tag;
      fifo_dst[wr_ptr]    <= e1_dst_val;
      fifo_pc[wr_ptr]     <= e1_pc;
    end
  end

  // Result buffer pointers and occupancy; kill overrides push and pop.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (kill_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Head decode for writeback and forwarding broadcast
  always_comb begin
    wb_valid_o       = (count != 2'd0);
    wb_result_o      = '0;
    wb_rrf_tag_o     = '0;
    wb_dst_val_o     = 1'b0;
    wb_pc_o          = '0;
    exe_result_o     = '0;
    exe_result_dst_o = '0;
    if (wb_valid_o) begin
      wb_result_o  = fifo_result[rd_ptr];
      wb_rrf_tag_o = fifo_tag[rd_ptr];
      wb_dst_val_o = fifo_dst[rd_ptr];
      wb_pc_o      = fifo_pc[rd_ptr];
      if (fifo_dst[rd_ptr]) begin
        exe_result_o     = fifo_result[rd_ptr];
        exe_result_dst_o = fifo_tag[rd_ptr];
      end
    end
  end

`ifdef ALU_EXE_PERF_CNT_EN
  // Performance counters, deliberately not cleared by kill
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_issue_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (issue_accept)                  perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
      if (issue_valid_i & issue_stall_o) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
